// File: rtl/store_pkg.sv
// Shared store-buffer definitions: store opcodes plus byte-enable and lane-replication helpers.
// Helpers are sized for the widest (64-bit) word; callers truncate to their own lane count.
package store_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SD = 6'b111111;

  localparam int MAX_NB = 8;

  // Offset bits below the access size are dropped here, which is what gives forced alignment.
  function automatic logic [MAX_NB-1:0] gen_be(input logic [5:0] op, input logic [2:0] off);
    logic [MAX_NB-1:0] be;
    be = '0;
    case (op)
      OP_SB:   be = 8'h01 << off;
      OP_SH:   be = 8'h03 << {off[2:1], 1'b0};
      OP_SW:   be = 8'h0F << {off[2], 2'b00};
      OP_SD:   be = 8'hFF;
      default: be = '0;
    endcase
    return be;
  endfunction

  function automatic logic [8*MAX_NB-1:0] rep_data(input logic [5:0] op, input logic [8*MAX_NB-1:0] d);
    logic [8*MAX_NB-1:0] r;
    r = '0;
    case (op)
      OP_SB:   r = {8{d[7:0]}};
      OP_SH:   r = {4{d[15:0]}};
      OP_SW:   r = {2{d[31:0]}};
      OP_SD:   r = d;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous FIFO with register-held storage, full/empty flags and an occupancy count.
// Push while full and pop while empty are ignored.
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: decodes SB/SH/SW/SD into byte enables plus lane-replicated data and queues them for memory.
// Define STORE_MISALIGN_EXC_EN to trap misaligned stores instead of force-aligning them.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [5:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NB-1:0]     mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              buf_empty,
  output logic [CW-1:0]     buf_count,
  output logic              st_exc,
  output logic [ADDR_W-1:0] exc_addr
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t     push_ent, head_ent;
  logic [2:0] off;
  logic       is_store, hs, push, pop, full, empty;

  assign off = 3'(st_addr[OW-1:0]);

  always_comb begin
    is_store = 1'b0;
    case (st_op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      OP_SD:               is_store = (DATA_W == 64);
      default:             is_store = 1'b0;
    endcase
  end

  assign st_ready       = ~full;
  assign hs             = st_valid & st_ready;
  assign push_ent.addr  = {st_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign push_ent.be    = NB'(gen_be(st_op, off));
  assign push_ent.wdata = DATA_W'(rep_data(st_op, 64'(st_data)));

`ifdef STORE_MISALIGN_EXC_EN
  logic              misaligned, exc_d, exc_q;
  logic [ADDR_W-1:0] exc_addr_d, exc_addr_q;

  always_comb begin
    misaligned = 1'b0;
    case (st_op)
      OP_SH:   misaligned = off[0];
      OP_SW:   misaligned = |off[1:0];
      OP_SD:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end

  // A misaligned store is still consumed; it just never reaches the queue.
  assign push       = hs & is_store & ~misaligned;
  assign exc_d      = hs & is_store & misaligned;
  assign exc_addr_d = exc_d ? st_addr : exc_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign st_exc   = exc_q;
  assign exc_addr = exc_addr_q;
`else
  assign push     = hs & is_store;
  assign st_exc   = 1'b0;
  assign exc_addr = '0;
`endif

  assign pop = mem_valid & mem_ready;

  store_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_ent),
    .pop_i   (pop),
    .rdata_o (head_ent),
    .full_o  (full),
    .empty_o (empty),
    .count_o (buf_count)
  );

  assign mem_valid = ~empty;
  assign mem_addr  = head_ent.addr;
  assign mem_be    = head_ent.be;
  assign mem_wdata = head_ent.wdata;
  assign buf_empty = empty;

endmodule
